// File: rtl/ram_137250_arb_pkg.sv
// Shared encodings and geometry for the 137250 scratch RAM arbiter and its
// clear sequencer.
package ram_137250_arb_pkg;

   localparam int RAM_DEPTH = 256;
   localparam int RAM_AW    = 8;
   localparam int RAM_DW    = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CLR  = 2'd1,
      GNT_VID  = 2'd2,
      GNT_CPU  = 2'd3
   } gnt_t;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : (v + 4'd1);
   endfunction

endpackage

// File: rtl/ram_137250_arb_clear_seq.sv
// Clear sequencer: walks every RAM address once from 0 after reset or on
// start, then parks in IDLE.
module ram_clear_seq
   import ram_137250_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic [RAM_AW-1:0] addr
);

   localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(RAM_DEPTH - 1);
   localparam logic [RAM_AW-1:0] ADDR_ONE  = RAM_AW'(1);

   logic [0:0]        state_r;
   logic [RAM_AW-1:0] addr_r;

   // Sweep state and address; a start while sweeping is ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_CLEAR;
         addr_r  <= {RAM_AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_CLEAR;
                  addr_r  <= {RAM_AW{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (addr_r == LAST_ADDR) begin
                  state_r <= ST_IDLE;
                  addr_r  <= {RAM_AW{1'b0}};
               end else begin
                  addr_r  <= addr_r + ADDR_ONE;
               end
            end
            default: begin
               state_r <= ST_CLEAR;
               addr_r  <= {RAM_AW{1'b0}};
            end
         endcase
      end
   end

   assign busy = (state_r == ST_CLEAR);
   assign addr = addr_r;

endmodule

// File: rtl/ram_137250_arb.sv
// Arbiter in front of the 256x4 scratch RAM: clear sequencer, CPU port with
// starvation guard, and a pipelined video read port.
module ram_137250_arb
   import ram_137250_arb_pkg::*;
#(
   parameter logic [3:0] CLR_VALUE = 4'h0,
   parameter logic [3:0] MAX_WAIT  = 4'd4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [RAM_DW-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [RAM_DW-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [RAM_AW-1:0] vid_addr,
   output logic              vid_valid,
   output logic [RAM_DW-1:0] vid_rdata,
   output logic              vid_drop,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic [RAM_AW-1:0] ram_a,
   output logic [RAM_DW-1:0] ram_i,
   output logic              ram_w,
   output logic              ram_cs1,
   output logic              ram_cs2,
   output logic              ram_oe,
   input  logic [RAM_DW-1:0] ram_d
);

   logic              clr_busy_s;
   logic [RAM_AW-1:0] clr_addr_s;
   logic              cpu_elig_s;
   gnt_t              gnt_s;

   logic              cpu_gnt_r;
   logic              cpu_ack_r;
   logic              cpu_rd_r;
   logic [RAM_DW-1:0] rdata_hold_r;
   logic              vid_valid_r;
   logic              vid_drop_r;
   logic [3:0]        wait_cnt_r;

   ram_clear_seq u_clear_seq (
      .clk   (clk),
      .reset (reset),
      .start (clr_start),
      .busy  (clr_busy_s),
      .addr  (clr_addr_s)
   );

   // A CPU request granted last cycle sits out one cycle so a held request is not serviced twice
   assign cpu_elig_s = cpu_req && !cpu_gnt_r;

   // Grant: clear > forced CPU > video > CPU; nothing is granted while reset is held
   always_comb begin
      gnt_s = GNT_NONE;
      if (reset) begin
         gnt_s = GNT_NONE;
      end else if (clr_busy_s) begin
         gnt_s = GNT_CLR;
      end else if (cpu_elig_s && (wait_cnt_r == MAX_WAIT)) begin
         gnt_s = GNT_CPU;
      end else if (vid_req) begin
         gnt_s = GNT_VID;
      end else if (cpu_elig_s) begin
         gnt_s = GNT_CPU;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // RAM pin drive for the granted source
   always_comb begin
      ram_a = {RAM_AW{1'b0}};
      ram_i = {RAM_DW{1'b0}};
      ram_w = 1'b1;
      case (gnt_s)
         GNT_CLR: begin
            ram_a = clr_addr_s;
            ram_i = CLR_VALUE;
            ram_w = 1'b0;
         end
         GNT_CPU: begin
            ram_a = cpu_addr;
            ram_i = cpu_wdata;
            ram_w = !cpu_we;
         end
         GNT_VID: begin
            ram_a = vid_addr;
         end
         default: begin
            ram_a = {RAM_AW{1'b0}};
         end
      endcase
   end

   // Response pipeline, CPU read hold register and video-starvation wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_gnt_r    <= 1'b0;
         cpu_ack_r    <= 1'b0;
         cpu_rd_r     <= 1'b0;
         rdata_hold_r <= {RAM_DW{1'b0}};
         vid_valid_r  <= 1'b0;
         vid_drop_r   <= 1'b0;
         wait_cnt_r   <= 4'd0;
      end else begin
         cpu_gnt_r   <= (gnt_s == GNT_CPU);
         cpu_ack_r   <= (gnt_s == GNT_CPU);
         cpu_rd_r    <= (gnt_s == GNT_CPU) && !cpu_we;
         vid_valid_r <= (gnt_s == GNT_VID);
         vid_drop_r  <= vid_req && (gnt_s != GNT_VID);
         if (cpu_ack_r && cpu_rd_r) begin
            rdata_hold_r <= ram_d;
         end
         if (clr_busy_s) begin
            wait_cnt_r <= wait_cnt_r;
         end else if (!cpu_req || (gnt_s == GNT_CPU)) begin
            wait_cnt_r <= 4'd0;
         end else if (cpu_elig_s && (gnt_s == GNT_VID)) begin
            wait_cnt_r <= sat_inc4(wait_cnt_r);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   assign cpu_ack   = cpu_ack_r;
   assign cpu_rdata = (cpu_ack_r && cpu_rd_r) ? ram_d : rdata_hold_r;
   assign vid_valid = vid_valid_r;
   assign vid_rdata = ram_d;
   assign vid_drop  = vid_drop_r;
   assign clr_busy  = clr_busy_s;
   assign ram_cs1   = 1'b0;
   assign ram_cs2   = 1'b1;
   assign ram_oe    = 1'b0;

endmodule

// File: tb/tb_ram_137250_arb.sv
// Self-checking bench for ram_137250_arb with a behavioural 256x4 synchronous RAM.
module tb_ram_137250_arb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_req = 1'b0;
   logic       cpu_we = 1'b0;
   logic [7:0] cpu_addr = 8'h00;
   logic [3:0] cpu_wdata = 4'h0;
   logic       cpu_ack;
   logic [3:0] cpu_rdata;
   logic       vid_req = 1'b0;
   logic [7:0] vid_addr = 8'h00;
   logic       vid_valid;
   logic [3:0] vid_rdata;
   logic       vid_drop;
   logic       clr_start = 1'b0;
   logic       clr_busy;
   logic [7:0] ram_a;
   logic [3:0] ram_i;
   logic       ram_w;
   logic       ram_cs1, ram_cs2, ram_oe;
   logic [3:0] ram_d;

   logic [3:0] mem [256];
   logic [3:0] exp_mem [256];
   logic [3:0] cpu_q [$];
   logic [3:0] vid_q [$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_137250_arb dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
      .vid_rdata(vid_rdata), .vid_drop(vid_drop),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .ram_a(ram_a), .ram_i(ram_i), .ram_w(ram_w),
      .ram_cs1(ram_cs1), .ram_cs2(ram_cs2), .ram_oe(ram_oe),
      .ram_d(ram_d)
   );

   // RAM part: write on low ram_w, registered read of the presented address
   always @(posedge clk) begin
      if (!ram_w) mem[ram_a] <= ram_i;
      ram_d <= mem[ram_a];
   end

   task automatic clear_model();
      for (int k = 0; k < 256; k++) exp_mem[k] = 4'h0;
   endtask

   task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [3:0] wdata);
      int   gcyc;
      bit   acked;
      logic [3:0] e;
      gcyc = -1;
      acked = 0;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      if (!we) cpu_q.push_back(exp_mem[addr]);
      else exp_mem[addr] = wdata;
      for (int n = 0; n < 40 && !acked; n++) begin
         @(negedge clk);
         if (cpu_ack) begin
            acked = 1;
            cpu_req = 1'b0;
            checks++;
            if (gcyc < 0 || n != gcyc + 1) begin
               failures++;
               $display("FAIL cpu_ack_latency addr=%h ack_cycle=%0d grant_cycle=%0d (want grant+1)", addr, n, gcyc);
            end
            if (!we) begin
               e = cpu_q.pop_front();
               checks++;
               if (cpu_rdata !== e) begin
                  failures++;
                  $display("FAIL cpu_read_data addr=%h got=%h exp=%h", addr, cpu_rdata, e);
               end
            end
         end else if (gcyc < 0 && ram_a === addr && ram_w === !we && !clr_busy) begin
            gcyc = n;
         end
         if (!acked) begin @(posedge clk); #1; end
      end
      if (!acked) begin
         checks++; failures++;
         cpu_req = 1'b0;
         $display("FAIL cpu_ack_timeout addr=%h got=no_ack exp=ack", addr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({clr_busy, cpu_ack, vid_valid, vid_drop, cpu_rdata, ram_w, ram_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL reset_values got=%b_%b%b%b_%h_%b_%h exp=1_000_0_1_00", clr_busy, cpu_ack, vid_valid, vid_drop, cpu_rdata, ram_w, ram_a);
      end
      checks++;
      if ({ram_cs1, ram_cs2, ram_oe} !== 3'b010) begin
         failures++;
         $display("FAIL tie_offs got=%b%b%b exp=010", ram_cs1, ram_cs2, ram_oe);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         checks++;
         if ({clr_busy, ram_w, ram_a, ram_i} !== {1'b1, 1'b0, i[7:0], 4'h0}) begin
            failures++;
            $display("FAIL init_clear i=%0d got busy=%b w=%b a=%h d=%h exp busy=1 w=0 a=%h d=0", i, clr_busy, ram_w, ram_a, ram_i, i[7:0]);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL init_clear_end got busy=%b exp=0", clr_busy);
      end
      clear_model();
      cpu_access(1'b0, 8'h7F, 4'h0);
   endtask

   task automatic test_cpu();
      cpu_access(1'b1, 8'h12, 4'hA);
      cpu_access(1'b0, 8'h12, 4'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (cpu_rdata !== 4'hA) begin
         failures++;
         $display("FAIL cpu_rdata_hold got=%h exp=a", cpu_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int grants [$];
      int acks [$];
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (ram_a === 8'h12 && ram_w === 1'b1) grants.push_back(n);
         if (cpu_ack) begin
            acks.push_back(n);
            checks++;
            if (cpu_rdata !== exp_mem[8'h12]) begin
               failures++;
               $display("FAIL b2b_data cycle=%0d got=%h exp=%h", n, cpu_rdata, exp_mem[8'h12]);
            end
         end
         @(posedge clk); #1;
      end
      cpu_req = 1'b0;
      checks++;
      if (grants.size() != 3 || grants[0] != 0 || grants[1] != 2 || grants[2] != 4) begin
         failures++;
         $display("FAIL b2b_grants got=%p exp='{0,2,4}", grants);
      end
      checks++;
      if (acks.size() != 3 || acks[0] != 1 || acks[1] != 3 || acks[2] != 5) begin
         failures++;
         $display("FAIL b2b_acks got=%p exp='{1,3,5}", acks);
      end
   endtask

   task automatic test_video();
      logic [3:0] e;
      for (int k = 0; k < 16; k++) cpu_access(1'b1, k[7:0], k[3:0]);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) begin
            vid_req = 1'b1; vid_addr = i[7:0];
            vid_q.push_back(exp_mem[i]);
         end else begin
            vid_req = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (vid_valid !== (i >= 1 && i <= 16) || vid_drop !== 1'b0) begin
            failures++;
            $display("FAIL vid_stream i=%0d got valid=%b drop=%b exp valid=%b drop=0", i, vid_valid, vid_drop, (i >= 1 && i <= 16));
         end
         if (vid_valid && vid_q.size() > 0) begin
            e = vid_q.pop_front();
            checks++;
            if (vid_rdata !== e) begin
               failures++;
               $display("FAIL vid_data i=%0d got=%h exp=%h", i, vid_rdata, e);
            end
         end
         @(posedge clk); #1;
      end
      vid_q.delete();
   endtask

   task automatic test_forced();
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      for (int i = 0; i < 10; i++) begin
         vid_req = 1'b1; vid_addr = 8'h40 + i[7:0];
         @(negedge clk);
         checks++;
         if ((ram_a === 8'h05) !== (i == 4)) begin
            failures++;
            $display("FAIL forced_grant i=%0d got cpu_grant=%b exp=%b", i, (ram_a === 8'h05), (i == 4));
         end
         checks++;
         if (cpu_ack !== (i == 5) || vid_drop !== (i == 5)) begin
            failures++;
            $display("FAIL forced_resp i=%0d got ack=%b drop=%b exp=%b", i, cpu_ack, vid_drop, (i == 5));
         end
         if (cpu_ack) begin
            cpu_req = 1'b0;
            checks++;
            if (cpu_rdata !== exp_mem[5]) begin
               failures++;
               $display("FAIL forced_data got=%h exp=%h", cpu_rdata, exp_mem[5]);
            end
         end
         @(posedge clk); #1;
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;
   endtask

   task automatic test_clear_cmd();
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 4'h9;
      clr_start = 1'b1;
      for (int i = 0; i < 260; i++) begin
         clr_start = (i == 0 || i == 100);
         vid_req = (i >= 1 && i <= 257);
         vid_addr = 8'h33;
         @(negedge clk);
         if (i == 0) begin
            checks++;
            if (ram_a !== 8'h30 || ram_w !== 1'b0 || ram_i !== 4'h9 || clr_busy !== 1'b0) begin
               failures++;
               $display("FAIL clr_cmd_cpu_grant got a=%h w=%b d=%h busy=%b exp a=30 w=0 d=9 busy=0", ram_a, ram_w, ram_i, clr_busy);
            end
         end
         checks++;
         if (clr_busy !== (i >= 1 && i <= 256)) begin
            failures++;
            $display("FAIL clr_cmd_busy i=%0d got=%b exp=%b", i, clr_busy, (i >= 1 && i <= 256));
         end
         checks++;
         if (vid_drop !== (i >= 2 && i <= 257) || cpu_ack !== (i == 1)) begin
            failures++;
            $display("FAIL clr_cmd_resp i=%0d got drop=%b ack=%b exp drop=%b ack=%b", i, vid_drop, cpu_ack, (i >= 2 && i <= 257), (i == 1));
         end
         if (i >= 1 && i <= 256) begin
            checks++;
            if (ram_w !== 1'b0 || ram_a !== 8'(i - 1) || ram_i !== 4'h0) begin
               failures++;
               $display("FAIL clr_cmd_write i=%0d got w=%b a=%h d=%h exp w=0 a=%h d=0", i, ram_w, ram_a, ram_i, 8'(i - 1));
            end
         end
         if (i == 258) begin
            checks++;
            if (vid_valid !== 1'b1) begin
               failures++;
               $display("FAIL clr_cmd_vid_after got valid=%b exp=1", vid_valid);
            end
         end
         if (i == 1) cpu_req = 1'b0;
         @(posedge clk); #1;
      end
      clr_start = 1'b0;
      vid_req = 1'b0;
      clear_model();
      cpu_access(1'b0, 8'h30, 4'h0);
   endtask

   task automatic test_reset_midclear();
      bit found;
      found = 0;
      cpu_access(1'b1, 8'h44, 4'hC);
      cpu_access(1'b0, 8'h44, 4'h0);
      @(posedge clk); #1;
      clr_start = 1'b1;
      @(posedge clk); #1;
      clr_start = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         if (clr_busy && ram_a === 8'h80 && ram_w === 1'b0) found = 1;
         else begin @(posedge clk); #1; end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL midclear_timeout got=no_addr80 exp=addr80");
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({clr_busy, cpu_ack, vid_valid, vid_drop, cpu_rdata, ram_w, ram_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL midclear_reset_values got=%b_%b%b%b_%h_%b_%h exp=1_000_0_1_00", clr_busy, cpu_ack, vid_valid, vid_drop, cpu_rdata, ram_w, ram_a);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (clr_busy !== 1'b1 || ram_w !== 1'b0 || ram_a !== i[7:0]) begin
            failures++;
            $display("FAIL midclear_restart i=%0d got busy=%b w=%b a=%h exp busy=1 w=0 a=%h", i, clr_busy, ram_w, ram_a, i[7:0]);
         end
         @(posedge clk); #1;
      end
      found = 0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         if (!clr_busy) found = 1;
         else begin @(posedge clk); #1; end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL midclear_end_timeout got=busy exp=idle");
      end
      clear_model();
      cpu_access(1'b0, 8'h44, 4'h0);
   endtask

   initial begin
      test_reset();
      test_cpu();
      test_back_to_back();
      test_video();
      test_forced();
      test_clear_cmd();
      test_reset_midclear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_137250_arb.md
# ram_137250_arb

Single-port arbiter and initialiser for one 256x4 synchronous-read scratch RAM (137250 type) on the Food Fight video board. It shares the RAM between a CPU-side requester (read/write, handshaked) and a video scan reader (read-only, one strobe per cycle). It also owns an automatic clear sequencer that fills all 256 locations with a constant after reset or on command. It sits directly in front of the RAM instance and is the only block driving its address, data and write-enable pins.

## Interface
- CLR_VALUE, 4'h0, nibble written to every location during a clear
- MAX_WAIT, 4, cycles a pending CPU request may lose to video before it is forced through (1..15)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  8  CPU address
- cpu_wdata  in  4  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  4  CPU read data; valid in ack cycle, held until next CPU read completes
- vid_req  in  1  video read strobe, one read per asserted cycle
- vid_addr  in  8  video address
- vid_valid  out  1  video read data valid
- vid_rdata  out  4  video read data, valid with vid_valid
- vid_drop  out  1  pulse: a vid_req was not serviced
- clr_start  in  1  start a clear sequence
- clr_busy  out  1  clear in progress
- ram_a  out  8  RAM address
- ram_i  out  4  RAM write data
- ram_w  out  1  RAM write enable, active-low
- ram_cs1, ram_cs2, ram_oe  out  1 each  tied 0, 1, 0
- ram_d  in  4  RAM registered read data (valid one cycle after address)

## Operation
- Grant decided combinationally each cycle C from registered state and current requests; ram_a/ram_i/ram_w driven combinationally from the grant in C; RAM latches at end of C.
- Priority: clear > forced CPU > video > CPU.
- CPU eligible in C only if cpu_req=1 and no CPU grant in C-1; caps throughput at one access per two cycles and prevents double-servicing a held request.
- Wait counter: 4-bit, saturating. Increments each cycle an eligible CPU request loses to video; clears on CPU grant or when cpu_req=0. Forced CPU grant when counter = MAX_WAIT and CPU eligible.
- Video: any vid_req not granted in C (clear active or forced CPU) -> vid_drop=1 in C+1, vid_valid=0.
- Clear: states IDLE, CLEAR. Reset enters CLEAR with address 0. Each CLEAR cycle writes CLR_VALUE at the address, then increments it. After address 255, return to IDLE (no wrap). clr_start in IDLE -> CLEAR from address 0 next cycle. clr_start while in CLEAR is ignored.
- clr_busy=1 exactly while in CLEAR. No CPU or video grants in CLEAR. CPU requests wait; the wait counter is frozen.
- clr_start in the same cycle as a CPU grant: the grant completes (ack issued) and clear begins next cycle.

## Timing
- Reset values: clr_busy=1, cpu_ack=0, vid_valid=0, vid_drop=0, cpu_rdata=0, ram_w=1, ram_a=0, wait counter 0, clear address 0.
- CPU: grant in C -> cpu_ack=1 in C+1. For reads, cpu_rdata=ram_d in C+1, captured into hold register at end of C+1.
- Video: strobe granted in C -> vid_valid=1, vid_rdata=ram_d in C+1. Fully pipelined, one per cycle.
- Clear after reset: 256 cycles; first normal grant possible in the cycle after address 255 is written.
- Reset mid-clear or mid-access: pending ack/valid pulses are lost; clear restarts at 0.

## Structure
- Shared package: state encoding (IDLE/CLEAR), grant-source encoding (NONE/CLR/VID/CPU), RAM depth/width constants (256, 8, 4).
- One sub-module is natural: ram_clear_seq (8-bit address counter, busy flag, start/done). Arbitration, wait counter and response registers stay in the top.

## Test plan
- Reset release, no requests -> clr_busy high 256 cycles, ram_w low with ram_a 0..255 and ram_i=CLR_VALUE; then a CPU read of 0x7F returns 0x0.
- CPU write 0x12<-0xA, then read 0x12 -> each ack one cycle after grant; read returns 0xA. cpu_req held through the first ack issues a second access no earlier than two cycles after the first grant.
- vid_req every cycle, addresses 0x00..0x0F preloaded with index -> vid_valid every cycle, vid_rdata = addr&0xF, one-cycle latency, no drops.
- vid_req continuous plus cpu_req (MAX_WAIT=4) -> CPU forced on its 5th eligible cycle; exactly one vid_drop in the following cycle; cpu_ack in the cycle after the grant.
- clr_start during a CPU write grant -> ack delivered; clear starts next cycle; vid_req during the clear gives vid_drop each cycle; second clr_start mid-clear ignored (256 cycles total).
- reset asserted at clear address 0x80 -> outputs take reset values immediately; after release the clear restarts at 0x00.
